// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART tx core between N_SRC byte sources,
// with start-ack watchdog; optional inter-frame gap via UART_TX_ARB_GAP_EN.
//
// Ports:
//   clk, nrst        clock, async active-low reset
//   req, req_data    per-source request level and byte ([8k+7:8k])
//   grant, tx_start  1-cycle pulses on launch
//   tx_data          byte to the core, held until next launch
//   tx_busy, tx_done core handshake
//   busy, cur_src    arbiter owns core, source being sent (held)
//   err              1-cycle pulse: core never acknowledged start
module uart_tx_arbiter #(
  parameter int N_SRC    = 4,
  parameter int SRC_W    = 2,
  parameter int START_TO = 2500,
  parameter int GAP_CYC  = 1250
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [N_SRC-1:0]   req,
  input  logic [8*N_SRC-1:0] req_data,
  output logic [N_SRC-1:0]   grant,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  input  logic               tx_done,
  output logic               busy,
  output logic [SRC_W-1:0]   cur_src,
  output logic               err
);

  localparam int CNT_MAX =
    (START_TO > GAP_CYC) ? START_TO : GAP_CYC;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE
`ifdef UART_TX_ARB_GAP_EN
    , S_GAP
`endif
  } state_t;

`ifdef UART_TX_ARB_GAP_EN
  localparam state_t DONE_ST = S_GAP;
`else
  localparam state_t DONE_ST = S_IDLE;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SRC_W-1:0]   ptr_q, ptr_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic               start_q, start_d;
  logic [7:0]         data_q, data_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic               err_q, err_d;

  logic [SRC_W-1:0]   win;
  logic               win_vld;
  int                 idx;

  // Scan from ptr upward with wrap; descending loop
  // lets the closest set bit to ptr win.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % N_SRC;
      if (req[idx]) begin
        win     = SRC_W'(idx);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    start_d = 1'b0;
    data_d  = data_q;
    src_d   = src_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant_d = N_SRC'(1) << win;
          start_d = 1'b1;
          data_d  = req_data[8*win +: 8];
          src_d   = win;
          ptr_d   = (win == SRC_W'(N_SRC - 1)) ?
                    '0 : win + 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        // A fast core may finish without
        // ever showing busy.
        if (tx_done) begin
          cnt_d   = '0;
          state_d = DONE_ST;
        end else if (tx_busy) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_W'(START_TO - 1)) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (tx_done) begin
          cnt_d   = '0;
          state_d = DONE_ST;
        end
      end
`ifdef UART_TX_ARB_GAP_EN
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      start_q <= 1'b0;
      data_q  <= 8'h00;
      src_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      start_q <= start_d;
      data_q  <= data_d;
      src_q   <= src_d;
      err_q   <= err_d;
    end
  end

  assign grant    = grant_q;
  assign tx_start = start_q;
  assign tx_data  = data_q;
  assign cur_src  = src_q;
  assign err      = err_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table vectors, reset corners,
// randomized traffic against a queue-based round-robin model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

`ifdef UART_TX_ARB_GAP_EN
  localparam int GAP = 1250;
  localparam int N_RND = 15;
`else
  localparam int GAP = 0;
  localparam int N_RND = 40;
`endif
  localparam int START_TO = 2500;

  logic        clk = 1'b0;
  logic        nrst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic        busy;
  logic [1:0]  cur_src;
  logic        err;

  uart_tx_arbiter dut (
    .clk(clk), .nrst(nrst), .req(req),
    .req_data(req_data), .grant(grant),
    .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .busy(busy), .cur_src(cur_src), .err(err)
  );

  always #41.667 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;
  int t_done = -100;
  int t_err = -100;
  int prev_start = 0;
  int prev_kind = 0;
  int core_mode = 1;
  int core_lat = 2;
  int core_blen = 10;
  logic [7:0] dat [4];
  int order [$];

  typedef struct {
    logic [3:0] r;
    int         mode;
    int         src;
    logic [7:0] d;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data();
    req_data = {dat[3], dat[2], dat[1], dat[0]};
  endtask

  // Model: priority list; the winner moves to the back.
  task automatic pick(input logic [3:0] r, output int w);
    w = -1;
    foreach (order[k])
      if (w < 0 && r[order[k]]) w = order[k];
    if (w >= 0) begin
      while (order[0] != w)
        order.push_back(order.pop_front());
      order.push_back(order.pop_front());
    end
  endtask

  // Core model: mode 0 dead, 1 normal, 2 fast (done, no busy).
  initial begin
    int ph, cm, cc, cb;
    ph = 0; cm = 0; cc = 0; cb = 0;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (!nrst) begin
        ph = 0;
        tx_busy = 1'b0;
      end else if (ph == 0) begin
        if (tx_start && core_mode != 0) begin
          cm = core_mode; cc = core_lat;
          cb = core_blen; ph = 1;
        end
      end else if (ph == 1) begin
        cc--;
        if (cc == 0) begin
          if (cm == 1) begin
            tx_busy = 1'b1; cc = cb; ph = 2;
          end else begin
            tx_done = 1'b1; t_done = cyc; ph = 0;
          end
        end
      end else begin
        cc--;
        if (cc == 0) begin
          tx_busy = 1'b0; tx_done = 1'b1;
          t_done = cyc; ph = 0;
        end
      end
    end
  end

  // Busy must be high through the done (or gap) cycle
  // and low the cycle after; err comes with busy low.
  always @(posedge clk) begin
    #1;
    if (nrst) begin
      if (err) begin
        t_err = cyc;
        chk("err_busy_low", {31'd0, busy}, 0);
      end
      if (cyc == t_done + GAP)
        chk("busy_last", {31'd0, busy}, 1);
      if (cyc == t_done + GAP + 1)
        chk("busy_fall", {31'd0, busy}, 0);
    end
  end

  task automatic launch(input logic [3:0] r,
                        input int mode, input int lat,
                        input int blen, input int src,
                        input logic [7:0] d);
    int n, s;
    req = r;
    core_mode = mode; core_lat = lat; core_blen = blen;
    n = 0;
    while (!tx_start && n < 6000) begin
      step(); n++;
    end
    if (!tx_start) begin
      chk("start_timeout", 0, 1);
      return;
    end
    s = cyc;
    chk("grant", {28'd0, grant}, 32'd1 << src);
    chk("tx_data", {24'd0, tx_data}, {24'd0, d});
    chk("cur_src", {30'd0, cur_src}, src);
    chk("busy_on", {31'd0, busy}, 1);
    if (prev_kind == 1)
      chk("done_to_start", s - t_done, GAP + 2);
    else if (prev_kind == 2) begin
      chk("err_latency", t_err - prev_start, START_TO);
      chk("err_to_start", s - t_err, 1);
    end
    step();
    chk("pulse_clear", {29'd0, grant != 0, tx_start, err}, 0);
    prev_start = s;
    prev_kind = (mode == 0) ? 2 : 1;
  endtask

  task automatic drain();
    int n;
    req = 4'b0000;
    n = 0;
    while (busy && n < 6000) begin
      step(); n++;
    end
    chk("drain_idle", {31'd0, busy}, 0);
    step();
    if (prev_kind == 2)
      chk("err_latency", t_err - prev_start, START_TO);
    prev_kind = 0;
    step();
  endtask

  initial begin
    #9_000_000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int w, n, md;
    logic [3:0] r;
    tbl[0]  = '{4'b0100, 1, 2, 8'h61};
    tbl[1]  = '{4'b1111, 1, 3, 8'h70};
    tbl[2]  = '{4'b1111, 1, 0, 8'h53};
    tbl[3]  = '{4'b1111, 1, 1, 8'h6E};
    tbl[4]  = '{4'b1111, 1, 2, 8'h61};
    tbl[5]  = '{4'b1111, 1, 3, 8'h70};
    tbl[6]  = '{4'b1111, 1, 0, 8'h53};
    tbl[7]  = '{4'b0101, 2, 2, 8'h61};
    tbl[8]  = '{4'b0011, 1, 0, 8'h53};
    tbl[9]  = '{4'b1010, 0, 1, 8'h6E};
    tbl[10] = '{4'b1010, 1, 3, 8'h70};
    tbl[11] = '{4'b0110, 1, 1, 8'h6E};
    tbl[12] = '{4'b0001, 2, 0, 8'h53};
    tbl[13] = '{4'b1001, 1, 3, 8'h70};

    dat[0] = 8'h53; dat[1] = 8'h6E;
    dat[2] = 8'h61; dat[3] = 8'h70;
    set_data();
    order = '{0, 1, 2, 3};
    nrst = 1'b0;
    req = 4'hF;

    // Reset held with all requests pending.
    #2000;
    chk("rst_outputs",
        {grant, tx_start, tx_data, busy, cur_src, err}, 0);
    #150;
    nrst = 1'b1;
    @(negedge clk);
    chk("rst_no_grant", {27'd0, grant, tx_start}, 0);
    step();
    chk("rst_first_grant", {28'd0, grant}, 4'b0001);
    pick(4'hF, w);
    launch(4'hF, 1, 2, 10, w, dat[w]);

    for (int i = 0; i < 14; i++) begin
      pick(tbl[i].r, w);
      launch(tbl[i].r, tbl[i].mode, 2, 10,
             tbl[i].src, tbl[i].d);
    end
    drain();

    // Reset in the middle of a frame.
    pick(4'b0010, w);
    launch(4'b0010, 1, 2, 40, w, dat[w]);
    n = 0;
    while (!tx_busy && n < 50) begin
      step(); n++;
    end
    repeat (3) step();
    chk("mid_busy", {31'd0, busy}, 1);
    #10 nrst = 1'b0;
    #1;
    chk("mid_rst_out",
        {grant, tx_start, tx_data, busy, cur_src, err}, 0);
    req = 4'b0000;
    repeat (3) step();
    order = '{0, 1, 2, 3};
    prev_kind = 0;
    req = 4'b1010;
    nrst = 1'b1;
    pick(4'b1010, w);
    launch(4'b1010, 1, 2, 10, w, dat[w]);
    pick(4'b1000, w);
    launch(4'b1000, 1, 2, 10, w, dat[w]);
    drain();

    // Random traffic and core behaviour.
    for (int i = 0; i < N_RND; i++) begin
      r = 4'($urandom_range(1, 15));
      for (int k = 0; k < 4; k++)
        dat[k] = 8'($urandom);
      set_data();
      if ($urandom_range(0, 9) == 0) md = 0;
      else if ($urandom_range(0, 3) == 0) md = 2;
      else md = 1;
      pick(r, w);
      launch(r, md, $urandom_range(1, 4),
             $urandom_range(1, 12), w, dat[w]);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
